// File: rtl/fifo_pkg.sv
// Shared constants and the output-buffer state type for the syncfifo read-side drain.
package fifo_pkg;

  localparam int DEFAULT_DATAWIDTH = 32;
  localparam int FIFODEPTH         = 8;

  // The encoding doubles as the buffer occupancy.
  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } buf_state_e;

endpackage

// File: rtl/fifo_drain_if.sv
// Handshake bundle of fifo_drain: syncfifo read port plus the valid/ready output stream.
interface fifo_drain_if
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) ();

  logic                 fifo_empty;
  logic [DATAWIDTH-1:0] fifo_dout;
  logic                 fifo_cs;
  logic                 fifo_ren;
  logic                 m_valid;
  logic [DATAWIDTH-1:0] m_data;
  logic                 m_ready;

  // The drain controller itself.
  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_cs, fifo_ren, m_valid, m_data
  );

  // The syncfifo and the downstream consumer.
  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_cs, fifo_ren, m_valid, m_data
  );

endinterface

// File: rtl/fifo_drain_skid.sv
// Two-entry output buffer: absorbs the one-cycle FIFO read latency under valid/ready backpressure.
module fifo_drain_skid
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DATAWIDTH-1:0] push_data,
  input  logic                 ready,
  output logic                 valid,
  output logic [DATAWIDTH-1:0] data,
  output logic [1:0]           occ
);

  buf_state_e           state_q, state_d;
  logic [DATAWIDTH-1:0] entry0_q, entry0_d;
  logic [DATAWIDTH-1:0] entry1_q, entry1_d;
  logic                 pop;

  assign valid = (state_q != S0);
  assign data  = entry0_q;
  assign occ   = state_q;
  assign pop   = valid && ready;

  always_comb begin
    // NOTE: every variable gets its hold value first, so no branch can leave one unassigned and infer a latch.
    state_d  = state_q;
    entry0_d = entry0_q;
    entry1_d = entry1_q;
    unique case (state_q)
      S0: begin
        if (push) begin
          state_d  = S1;
          entry0_d = push_data;
        end
      end
      S1: begin
        if (push && !pop) begin
          state_d  = S2;
          entry1_d = push_data;
        end else if (pop && !push) begin
          state_d = S0;
        end else if (push && pop) begin
          entry0_d = push_data;
        end
      end
      S2: begin
        if (pop) begin
          state_d  = S1;
          entry0_d = entry1_q;
        end
      end
      default: state_d = S0;
    endcase
  end

  // NOTE: non-blocking assignments in clocked processes so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S0;
      // NOTE: two discrete registers, not a RAM array, so resetting them is cheap and keeps m_data defined.
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      state_q  <= state_d;
      entry0_q <= entry0_d;
      entry1_q <= entry1_d;
    end
  end

  // The pop decision upstream keeps a landing word from ever meeting a full buffer.
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst)
    !((state_q == S2) && push));

endmodule

// File: rtl/fifo_drain.sv
// Read-side controller for syncfifo: issues pops, tracks the in-flight read, streams words out.
// Optional FIFO_DRAIN_CNT_EN adds a 16-bit wrapping count of accepted output beats.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATAWIDTH = DEFAULT_DATAWIDTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        busy,
  fifo_drain_if.master bus
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [15:0] beat_cnt
`endif
);

  logic       inflight_q, inflight_d;
  logic [1:0] occ;
  logic       head_pop;
  logic [2:0] pending;
  logic       ren;

  assign head_pop = bus.m_valid && bus.m_ready;

  // Words that will occupy the buffer after this edge if no new pop is issued.
  always_comb begin
    pending    = {1'b0, occ} - {2'b00, head_pop} + {2'b00, inflight_q};
    ren        = enable && !bus.fifo_empty && (pending < 3'd2);
    inflight_d = ren;
  end

  assign bus.fifo_ren = ren;
  assign bus.fifo_cs  = ren;
  assign busy         = inflight_q || (occ != 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  fifo_drain_skid #(
    .DATAWIDTH (DATAWIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (bus.fifo_dout),
    .ready     (bus.m_ready),
    .valid     (bus.m_valid),
    .data      (bus.m_data),
    .occ       (occ)
  );

`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] beat_cnt_q, beat_cnt_d;

  always_comb begin
    beat_cnt_d = beat_cnt_q + (head_pop ? 16'd1 : 16'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q <= 16'd0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// Scoreboard bench for fifo_drain with a behavioural syncfifo model on the read side.
module tb_fifo_drain;
  import fifo_pkg::*;

  localparam int DW = DEFAULT_DATAWIDTH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic busy;
`ifdef FIFO_DRAIN_CNT_EN
  logic [15:0] beat_cnt;
`endif

  always #5 clk = ~clk;

  fifo_drain_if #(.DATAWIDTH(DW)) bus ();

  fifo_drain #(.DATAWIDTH(DW)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .busy   (busy),
    .bus    (bus)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // ---------------- syncfifo model ----------------
  logic [DW-1:0] stim [0:255];
  int            stim_wr = 0;
  int            stim_rd = 0;
  logic [DW-1:0] fq [$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      fq.delete();
      stim_rd = stim_wr;
      bus.fifo_empty <= 1'b1;
      bus.fifo_dout  <= '0;
    end else begin
      if (bus.fifo_ren && bus.fifo_cs && !bus.fifo_empty)
        bus.fifo_dout <= fq.pop_front();
      while (stim_rd != stim_wr) begin
        fq.push_back(stim[stim_rd[7:0]]);
        stim_rd++;
      end
      bus.fifo_empty <= (fq.size() == 0);
    end
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q [$];
  int            acc_cnt = 0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_data = '0;

  task automatic load(input logic [DW-1:0] v);
    stim[stim_wr[7:0]] = v;
    stim_wr++;
    exp_q.push_back(v);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", bus.m_valid, 1);
        check("hold_data", bus.m_data, hold_data);
      end
      if (bus.m_valid && bus.m_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("data", bus.m_data, exp_q.pop_front());
        acc_cnt++;
      end
      hold_pend = bus.m_valid && !bus.m_ready;
      hold_data = bus.m_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_wait(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_ren, first_v, first_b, last_b, pops, base;

    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ren", bus.fifo_ren, 0);
    check("rst_cs", bus.fifo_cs, 0);
    check("rst_valid", bus.m_valid, 0);
    check("rst_data", bus.m_data, 0);
    check("rst_busy", busy, 0);
    tick();
    rst = 1'b1;

    // Reset in the middle of activity.
    for (int v = 1; v <= 3; v++) load(DW'(v));
    enable = 1'b1;
    repeat (6) @(negedge clk);
    check("pre_rst_valid", bus.m_valid, 1);
    check("pre_rst_busy", busy, 1);
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("arst_ren", bus.fifo_ren, 0);
    check("arst_valid", bus.m_valid, 0);
    check("arst_data", bus.m_data, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    tick();
    rst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_ren", bus.fifo_ren, 0);
      check("post_rst_valid", bus.m_valid, 0);
    end

    // Full-rate stream.
    tick();
    enable = 1'b0;
    bus.m_ready = 1'b1;
    for (int v = 1; v <= 5; v++) load(DW'(v));
    tick();
    tick();
    enable = 1'b1;
    base = acc_cnt;
    first_ren = -1; first_v = -1; first_b = -1; last_b = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.fifo_ren && first_ren < 0) first_ren = i;
      if (bus.m_valid && first_v < 0) first_v = i;
      if (bus.m_valid && bus.m_ready) begin
        if (first_b < 0) first_b = i;
        last_b = i;
      end
    end
    check("stream_latency", first_v - first_ren, 2);
    check("stream_span", last_b - first_b, 4);
    check("stream_beats", acc_cnt - base, 5);
    check("stream_ren_off", bus.fifo_ren, 0);
    check("stream_busy_off", busy, 0);
`ifdef FIFO_DRAIN_CNT_EN
    check("beat_cnt", beat_cnt, 5);
`endif

    // Backpressure: buffer fills with two words, then pops stop.
    tick();
    enable = 1'b0;
    bus.m_ready = 1'b0;
    for (int v = 1; v <= 8; v++) load(DW'(v));
    tick();
    tick();
    enable = 1'b1;
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.fifo_ren) pops++;
    end
    check("bp_pops", pops, 2);
    check("bp_ren_off", bus.fifo_ren, 0);
    check("bp_valid", bus.m_valid, 1);
    check("bp_data", bus.m_data, 1);
    check("bp_busy", busy, 1);
    tick();
    bus.m_ready = 1'b1;
    base = acc_cnt;
    first_b = -1; last_b = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.m_valid && bus.m_ready) begin
        if (first_b < 0) first_b = i;
        last_b = i;
      end
    end
    check("bp_span", last_b - first_b, 7);
    check("bp_beats", acc_cnt - base, 8);
    drain_wait(10);

    // Random backpressure.
    base = acc_cnt;
    for (int v = 10; v <= 17; v++) load(DW'(v));
    for (int i = 0; i < 400; i++) begin
      tick();
      bus.m_ready = 1'($urandom_range(0, 1));
      if (exp_q.size() == 0 && !busy) break;
    end
    drain_wait(10);
    check("rand_beats", acc_cnt - base, 8);

    // Enable dropped after the second pop.
    tick();
    bus.m_ready = 1'b1;
    enable = 1'b0;
    for (int v = 1; v <= 4; v++) load(DW'(v));
    tick();
    tick();
    base = acc_cnt;
    enable = 1'b1;
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.fifo_ren) pops++;
      if (pops == 2) break;
    end
    tick();
    enable = 1'b0;
    pops = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.fifo_ren) pops++;
    end
    check("en_off_pops", pops, 0);
    check("en_off_beats", acc_cnt - base, 2);
    check("en_off_valid", bus.m_valid, 0);
    tick();
    enable = 1'b1;
    drain_wait(30);
    check("en_on_beats", acc_cnt - base, 4);

    repeat (3) @(negedge clk);
    check("final_busy", busy, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
